mem_req_responder: RTL and testbench

- Target side of the 32-bit tagged mem_req/mem_resp bus that the Nios tester system drives as initiator.
- Accepts tagged read and write requests and stores data in an internal word RAM.
- Acknowledges each request with a rack strobe plus tag, and returns read data with a dack strobe plus tag after a fixed latency.
- Used as the on-chip memory target in tester builds and as the bus-functional responder in simulation.

---
 rtl/mem_req_responder.sv | 139 +++++++++++++
 tb/tb_mem_req_responder.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_responder.sv
`timescale 1ns/1ps
// Tagged mem_req/mem_resp target: word RAM with rack handshake and
// fixed-latency in-order read returns through a register delay line.
module mem_req_responder #(
    parameter int ADDR_BITS    = 10,
    parameter int READ_LATENCY = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mem_req_request,
    input  logic        mem_req_read_writen,
    input  logic [25:0] mem_req_address,
    input  logic [3:0]  mem_req_byte_en,
    input  logic [7:0]  mem_req_tag,
    input  logic [31:0] mem_req_wdata,
    input  logic        stall,
    output logic        mem_resp_rack,
    output logic [7:0]  mem_resp_rack_tag,
    output logic        mem_resp_dack,
    output logic [7:0]  mem_resp_dack_tag,
    output logic [31:0] mem_resp_data
);

    localparam int WORDS = 2 ** ADDR_BITS;

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t state;
    state_t state_next;

    logic                 accept;
    logic [ADDR_BITS-1:0] word_idx;
    logic                 unused_addr;

    logic [31:0] ram [WORDS];
    logic [31:0] ram_q;

    logic [7:0] ack_tag;
    logic       cap_valid;
    logic [7:0] cap_tag;

    logic [READ_LATENCY-1:0] dl_valid;
    logic [7:0]              dl_tag  [READ_LATENCY];
    logic [31:0]             dl_data [READ_LATENCY];

    // Upper address bits alias and byte-offset bits are don't-care.
    assign word_idx    = mem_req_address[ADDR_BITS+1:2];
    assign unused_addr = ^{mem_req_address[25:ADDR_BITS+2],
                           mem_req_address[1:0]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_req_request && !stall) begin
                    accept     = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Block RAM: one access per accepted request, no reset on contents.
    always_ff @(posedge clock) begin
        if (accept) begin
            if (mem_req_read_writen) begin
                ram_q <= ram[word_idx];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_req_byte_en[b]) begin
                        ram[word_idx][8*b +: 8] <= mem_req_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack_tag   <= '0;
            cap_valid <= 1'b0;
            cap_tag   <= '0;
        end else begin
            cap_valid <= accept && mem_req_read_writen;
            if (accept) begin
                ack_tag <= mem_req_tag;
                cap_tag <= mem_req_tag;
            end
        end
    end

    // Stage 0 is loaded in the rack cycle, so the last stage lands at
    // rack + READ_LATENCY.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dl_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dl_tag[i]  <= '0;
                dl_data[i] <= '0;
            end
        end else begin
            dl_valid[0] <= cap_valid;
            dl_tag[0]   <= cap_tag;
            dl_data[0]  <= ram_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_tag[i]   <= dl_tag[i-1];
                dl_data[i]  <= dl_data[i-1];
            end
        end
    end

    always_comb begin
        mem_resp_rack     = (state == ACK);
        mem_resp_rack_tag = mem_resp_rack ? ack_tag : 8'h00;
        mem_resp_dack     = dl_valid[READ_LATENCY-1];
        mem_resp_dack_tag = mem_resp_dack ? dl_tag[READ_LATENCY-1] : 8'h00;
        mem_resp_data     = mem_resp_dack ? dl_data[READ_LATENCY-1] : 32'h0;
    end

endmodule

// File: tb/tb_mem_req_responder.sv
`timescale 1ns/1ps
// Randomized bench for mem_req_responder with a queue/array reference
// model of the memory and of the expected read returns.
module tb_mem_req_responder;

    localparam int LAT = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        request = 1'b0;
    logic        rw = 1'b0;
    logic [25:0] address = '0;
    logic [3:0]  byte_en = '0;
    logic [7:0]  tag = '0;
    logic [31:0] wdata = '0;
    logic        stall = 1'b0;
    logic        rack;
    logic [7:0]  rack_tag;
    logic        dack;
    logic [7:0]  dack_tag;
    logic [31:0] rdata;

    mem_req_responder #(
        .ADDR_BITS(10),
        .READ_LATENCY(LAT)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .mem_req_request(request),
        .mem_req_read_writen(rw),
        .mem_req_address(address),
        .mem_req_byte_en(byte_en),
        .mem_req_tag(tag),
        .mem_req_wdata(wdata),
        .stall(stall),
        .mem_resp_rack(rack),
        .mem_resp_rack_tag(rack_tag),
        .mem_resp_dack(dack),
        .mem_resp_dack_tag(dack_tag),
        .mem_resp_data(rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic [7:0]  tag;
        logic [31:0] data;
    } ev_t;

    ev_t         rack_q[$];
    ev_t         dack_q[$];
    ev_t         exp_q[$];
    logic [31:0] ref_mem [1024];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          bad_idle = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        if (rack) rack_q.push_back(ev_t'{cyc, rack_tag, 32'h0});
        else if (rack_tag !== 8'h00) bad_idle++;
        if (dack) dack_q.push_back(ev_t'{cyc, dack_tag, rdata});
        else if (dack_tag !== 8'h00 || rdata !== 32'h0) bad_idle++;
    end

    task automatic drive(input logic r, input logic [25:0] a,
                         input logic [3:0] be, input logic [7:0] t,
                         input logic [31:0] wd);
        rw = r;
        address = a;
        byte_en = be;
        tag = t;
        wdata = wd;
        request = 1'b1;
    endtask

    // Present one request, wait for its rack, then fold it into the model.
    task automatic issue(input logic r, input logic [25:0] a,
                         input logic [3:0] be, input logic [7:0] t,
                         input logic [31:0] wd, input int hold_stall,
                         output int rc);
        int w;
        drive(r, a, be, t, wd);
        stall = (hold_stall > 0);
        rc = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #2;
            if (i + 1 >= hold_stall) stall = 1'b0;
            if (rack) begin
                rc = cyc;
                break;
            end
        end
        if (rc >= 0) begin
            w = (int'(a) / 4) % 1024;
            if (r) begin
                exp_q.push_back(ev_t'{rc + LAT, t, ref_mem[w]});
            end else begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    task automatic idle(input int n);
        request = 1'b0;
        stall = 1'b0;
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic clear_logs();
        rack_q.delete();
        dack_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        int c0;
        int rc;
        logic [7:0] t0;
        reset_n = 1'b0;
        drive(1'b1, 26'h100, 4'hF, 8'h77, 32'h0);
        repeat (3) @(posedge clock);
        #2;
        n_checks++;
        if (rack !== 1'b0) begin
            n_fail++; $display("FAIL reset_rack: got %b want 0", rack);
        end
        n_checks++;
        if (rack_tag !== 8'h00) begin
            n_fail++; $display("FAIL reset_rack_tag: got %h want 00", rack_tag);
        end
        n_checks++;
        if (dack !== 1'b0) begin
            n_fail++; $display("FAIL reset_dack: got %b want 0", dack);
        end
        n_checks++;
        if (dack_tag !== 8'h00 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dack_fields: got tag %h data %h want 0",
                     dack_tag, rdata);
        end
        drive(1'b0, 26'h300, 4'hF, 8'h5A, 32'hCAFEF00D);
        clear_logs();
        c0 = cyc;
        reset_n = 1'b1;
        rc = -1;
        t0 = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #2;
            if (rack) begin
                rc = cyc;
                t0 = rack_tag;
                break;
            end
        end
        ref_mem[192] = 32'hCAFEF00D;
        idle(2);
        n_checks++;
        if (rc !== c0 + 1) begin
            n_fail++; $display("FAIL reset_first_rack: got cycle %0d want %0d", rc, c0 + 1);
        end
        n_checks++;
        if (t0 !== 8'h5A) begin
            n_fail++; $display("FAIL reset_first_tag: got %h want 5a", t0);
        end
    endtask

    task automatic test_write_read();
        int r1;
        int r2;
        clear_logs();
        issue(1'b0, 26'h000100, 4'hF, 8'h11, 32'hDEADBEEF, 0, r1);
        idle(2);
        issue(1'b1, 26'h000100, 4'hF, 8'h22, 32'h0, 0, r2);
        idle(LAT + 3);
        n_checks++;
        if (rack_q.size() !== 2 || rack_q[0].tag !== 8'h11 ||
            rack_q[0].cyc !== r1) begin
            n_fail++;
            $display("FAIL wr_rack: got %0d racks want 2 (first tag 11 at %0d)",
                     rack_q.size(), r1);
        end
        n_checks++;
        if (dack_q.size() !== 1) begin
            n_fail++; $display("FAIL wr_dack_count: got %0d want 1", dack_q.size());
        end else begin
            n_checks++;
            if (dack_q[0].cyc !== r2 + 4 || dack_q[0].tag !== 8'h22 ||
                dack_q[0].data !== 32'hDEADBEEF) begin
                n_fail++;
                $display("FAIL wr_dack: got cyc %0d tag %h data %h want cyc %0d tag 22 data deadbeef",
                         dack_q[0].cyc, dack_q[0].tag, dack_q[0].data, r2 + 4);
            end
        end
    endtask

    task automatic test_byte_en();
        int r1;
        int r2;
        clear_logs();
        issue(1'b0, 26'h000100, 4'b0101, 8'h33, 32'h11223344, 0, r1);
        issue(1'b1, 26'h000100, 4'hF, 8'h44, 32'h0, 0, r2);
        idle(LAT + 3);
        n_checks++;
        if (r2 - r1 !== 2) begin
            n_fail++; $display("FAIL be_rack_spacing: got %0d want 2", r2 - r1);
        end
        n_checks++;
        if (dack_q.size() !== 1 || dack_q[0].data !== 32'hDE22BE44 ||
            dack_q[0].tag !== 8'h44 || dack_q[0].cyc !== r2 + 4) begin
            n_fail++;
            $display("FAIL be_merge: got %0d dacks first data %h want 1 dack de22be44",
                     dack_q.size(), dack_q.size() > 0 ? dack_q[0].data : 32'h0);
        end
    endtask

    task automatic test_pipelined();
        int r[3];
        logic [25:0] a[3];
        bit hit;
        a[0] = 26'h100;
        a[1] = 26'h300;
        a[2] = 26'h100;
        clear_logs();
        for (int i = 0; i < 3; i++)
            issue(1'b1, a[i], 4'hF, 8'(i + 1), 32'h0, 0, r[i]);
        idle(LAT + 3);
        n_checks++;
        if (r[1] - r[0] !== 2 || r[2] - r[1] !== 2) begin
            n_fail++;
            $display("FAIL pipe_rack_rate: got gaps %0d %0d want 2 2",
                     r[1] - r[0], r[2] - r[1]);
        end
        n_checks++;
        if (dack_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL pipe_dack_count: got %0d want %0d", dack_q.size(), exp_q.size());
        end
        for (int i = 0; i < dack_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (dack_q[i] != exp_q[i]) begin
                n_fail++;
                $display("FAIL pipe_dack[%0d]: got cyc %0d tag %h data %h want cyc %0d tag %h data %h",
                         i, dack_q[i].cyc, dack_q[i].tag, dack_q[i].data,
                         exp_q[i].cyc, exp_q[i].tag, exp_q[i].data);
            end
        end
        hit = 0;
        foreach (dack_q[i])
            foreach (rack_q[j])
                if (dack_q[i].cyc == rack_q[j].cyc) hit = 1;
        n_checks++;
        if (hit !== 1'b1) begin
            n_fail++; $display("FAIL pipe_coincide: got %b want 1", hit);
        end
    endtask

    task automatic test_stall();
        int c0;
        clear_logs();
        drive(1'b0, 26'h000304, 4'hF, 8'h99, 32'h01020304);
        stall = 1'b1;
        repeat (5) @(posedge clock);
        #2;
        n_checks++;
        if (rack_q.size() !== 0) begin
            n_fail++; $display("FAIL stall_block: got %0d racks want 0", rack_q.size());
        end
        c0 = cyc;
        stall = 1'b0;
        @(posedge clock);
        #2;
        ref_mem[193] = 32'h01020304;
        n_checks++;
        if (rack !== 1'b1 || rack_tag !== 8'h99 || cyc !== c0 + 1) begin
            n_fail++; $display("FAIL stall_release: got rack %b tag %h want 1 99", rack, rack_tag);
        end
        idle(4);
        n_checks++;
        if (rack_q.size() !== 1) begin
            n_fail++; $display("FAIL stall_single: got %0d racks want 1", rack_q.size());
        end
    endtask

    task automatic test_alias();
        int r1;
        clear_logs();
        issue(1'b1, 26'h001100, 4'hF, 8'h00, 32'h0, 0, r1);
        idle(LAT + 3);
        n_checks++;
        if (dack_q.size() !== 1 || dack_q[0].tag !== 8'h00 ||
            dack_q[0].data !== 32'hDE22BE44 || dack_q[0].cyc !== r1 + 4) begin
            n_fail++;
            $display("FAIL alias_read: got %0d dacks data %h want 1 dack de22be44",
                     dack_q.size(), dack_q.size() > 0 ? dack_q[0].data : 32'h0);
        end
    endtask

    task automatic test_reset_flush();
        int r1;
        clear_logs();
        issue(1'b1, 26'h000100, 4'hF, 8'h55, 32'h0, 0, r1);
        request = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        idle(LAT + 4);
        n_checks++;
        if (r1 < 0 || dack_q.size() !== 0) begin
            n_fail++;
            $display("FAIL flush_dack: got %0d dacks (rack %0d) want 0", dack_q.size(), r1);
        end
        clear_logs();
        issue(1'b1, 26'h000300, 4'hF, 8'h66, 32'h0, 0, r1);
        idle(LAT + 3);
        n_checks++;
        if (dack_q.size() !== 1 || dack_q[0].data !== 32'hCAFEF00D ||
            dack_q[0].tag !== 8'h66 || dack_q[0].cyc !== r1 + 4) begin
            n_fail++; $display("FAIL flush_recover: got %0d dacks want 1", dack_q.size());
        end
    endtask

    task automatic test_random();
        int rc;
        int n_issued;
        logic [7:0] tags[$];
        logic r;
        logic [25:0] a;
        logic [7:0] t;
        clear_logs();
        n_issued = 0;
        for (int w = 0; w < 8; w++) begin
            t = 8'(w);
            issue(1'b0, 26'(32'h200 + w * 4), 4'hF, t, $urandom, 0, rc);
            tags.push_back(t);
            n_issued++;
        end
        for (int k = 0; k < 60; k++) begin
            r = 1'($urandom_range(0, 1));
            a = 26'(32'h200 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3) +
                    ($urandom_range(0, 15) << 12));
            t = 8'($urandom);
            issue(r, a, 4'($urandom), t, $urandom,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, rc);
            tags.push_back(t);
            n_issued++;
            n_checks++;
            if (rc < 0) begin
                n_fail++; $display("FAIL rand_timeout[%0d]: got no rack want rack", k);
            end
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(LAT + 4);
        n_checks++;
        if (rack_q.size() !== n_issued) begin
            n_fail++; $display("FAIL rand_rack_count: got %0d want %0d", rack_q.size(), n_issued);
        end
        for (int i = 0; i < rack_q.size() && i < tags.size(); i++) begin
            n_checks++;
            if (rack_q[i].tag !== tags[i]) begin
                n_fail++;
                $display("FAIL rand_rack_tag[%0d]: got %h want %h", i, rack_q[i].tag, tags[i]);
            end
        end
        n_checks++;
        if (dack_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rand_dack_count: got %0d want %0d", dack_q.size(), exp_q.size());
        end
        for (int i = 0; i < dack_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (dack_q[i] != exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_dack[%0d]: got cyc %0d tag %h data %h want cyc %0d tag %h data %h",
                         i, dack_q[i].cyc, dack_q[i].tag, dack_q[i].data,
                         exp_q[i].cyc, exp_q[i].tag, exp_q[i].data);
            end
        end
        n_checks++;
        if (bad_idle !== 0) begin
            n_fail++; $display("FAIL idle_outputs_zero: got %0d violations want 0", bad_idle);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_en();
        test_pipelined();
        test_stall();
        test_alias();
        test_reset_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
